codix_dbus_mem_slave: RTL

//  Single-port data-memory slave on the codix_risc_ca dbus; directly downstream of the CPU dbus master.

---
 rtl/codix_dbus_pkg.sv | 65 ++++++
 rtl/codix_dbus_byte_lane.sv | 48 ++++
 rtl/codix_dbus_mem_slave.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/codix_dbus_pkg.sv
// Shared types and helpers for the codix dbus data-memory slave.
// Contents: command/response encodings, transfer size, slave FSM states,
// CMD_W (width of every dbus command/response field), size_incr() (burst
// address step per size) and misaligned() (alignment test for a request).
package codix_dbus_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    REQ_IDLE  = 3'd0,
    REQ_READ  = 3'd1,
    REQ_WRITE = 3'd2
  } req_cmd_e;

  typedef enum logic [CMD_W-1:0] {
    RESP_WAIT = 3'd0,
    RESP_ACK  = 3'd1,
    RESP_ERR  = 3'd2
  } req_resp_e;

  typedef enum logic [CMD_W-1:0] {
    IF_IDLE = 3'd0,
    IF_READ = 3'd1
  } if_cmd_e;

  typedef enum logic [CMD_W-1:0] {
    OF_IDLE  = 3'd0,
    OF_WRITE = 3'd2
  } of_cmd_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD      = 2'd2,
    ST_WR      = 2'd3
  } mem_state_e;

  // Byte-address step between consecutive burst beats.
  function automatic logic [2:0] size_incr(size_e sz);
    case (sz)
      SZ_BYTE: size_incr = 3'd1;
      SZ_HALF: size_incr = 3'd2;
      default: size_incr = 3'd4;
    endcase
  endfunction

  // True when the low address bits do not match the natural alignment of
  // the size, or the size code is the reserved one.
  function automatic logic misaligned(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = |lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/codix_dbus_byte_lane.sv
// Little-endian byte-lane steering for the dbus memory slave (combinational).
// Ports:
//   addr_lo        in   2  byte offset inside the 32-bit word
//   size           in   2  transfer size (reserved code behaves as word)
//   rdata          in  32  raw memory word
//   wdata          in  32  right-justified write data from the master
//   be             out  4  byte enables for the write
//   rdata_shifted  out 32  selected lanes shifted to bit 0, zero-extended
//   wdata_repl     out 32  write data replicated onto every candidate lane
module codix_dbus_byte_lane
  import codix_dbus_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] rdata_shifted,
  output logic [31:0] wdata_repl
);

  logic [31:0] rdata_sh;

  always_comb begin
    rdata_sh      = rdata >> {addr_lo, 3'b000};
    be            = 4'b1111;
    rdata_shifted = rdata_sh;
    wdata_repl    = wdata;
    case (size)
      SZ_BYTE: begin
        be            = 4'b0001 << addr_lo;
        rdata_shifted = {24'd0, rdata_sh[7:0]};
        wdata_repl    = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be            = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata_shifted = {16'd0, rdata_sh[15:0]};
        wdata_repl    = {2{wdata[15:0]}};
      end
      default: begin
        be            = 4'b1111;
        rdata_shifted = rdata_sh;
        wdata_repl    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/codix_dbus_mem_slave.sv
// Single-port data-memory slave on the codix dbus.
// Accepts READ/WRITE requests, returns read beats on Q0/IFRESP0 after RD_LAT
// wait cycles and absorbs write beats on D0/OFRESP0. Sized (byte/half/word)
// and incrementing bursts of 1..8 beats; addresses wrap modulo memory size.
// Optional macro CODIX_DBUS_MEM_ALIGN_CHK_EN: reject misaligned requests with
// REQRESP=ERR and an err_o pulse; without it low address bits are masked.
// Ports:
//   CLK, RST (sync, active-low)
//   dbus_A0/SI0/SC0/REQCMD0 in, dbus_REQRESP0 out   request phase
//   dbus_IFCMD0 in, dbus_IFRESP0/Q0 out             read beats
//   dbus_OFCMD0/D0 in, dbus_OFRESP0 out             write beats
//   busy_o (state != IDLE), err_o (rejected request pulse)
module codix_dbus_mem_slave
  import codix_dbus_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      dbus_A0,
  input  logic [1:0]       dbus_SI0,
  input  logic [2:0]       dbus_SC0,
  input  logic [CMD_W-1:0] dbus_REQCMD0,
  output logic [CMD_W-1:0] dbus_REQRESP0,
  output logic [31:0]      dbus_Q0,
  input  logic [CMD_W-1:0] dbus_IFCMD0,
  output logic [CMD_W-1:0] dbus_IFRESP0,
  input  logic [31:0]      dbus_D0,
  input  logic [CMD_W-1:0] dbus_OFCMD0,
  output logic [CMD_W-1:0] dbus_OFRESP0,
  output logic             busy_o,
  output logic             err_o
);

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  mem_state_e        state_reg, state_next;
  logic [ADDR_W+1:0] addr_reg, addr_next;
  size_e             size_reg, size_next;
  logic [3:0]        beats_reg, beats_next;
  logic [3:0]        wait_reg, wait_next;
  logic [CMD_W-1:0]  req_resp_reg, req_resp_next;
  logic [31:0]       q_reg, q_next;
  logic              err_reg, err_next;

  logic              if_ack, of_ack, wr_en;
  logic              req_valid, req_bad;
  size_e             req_size, req_size_eff;
  logic [1:0]        req_lo;
  logic [ADDR_W+1:0] addr_incr, lane_addr;
  logic [3:0]        be;
  logic [31:0]       rd_data, rdata_shifted, wdata_repl;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^dbus_A0[31:ADDR_W+2];

  // Request decode: the reserved size acts as word and the low address bits
  // are forced to the size alignment before being latched.
  always_comb begin
    req_size     = size_e'(dbus_SI0);
    req_size_eff = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    case (req_size_eff)
      SZ_BYTE: req_lo = dbus_A0[1:0];
      SZ_HALF: req_lo = {dbus_A0[1], 1'b0};
      default: req_lo = 2'b00;
    endcase
  end

  assign req_valid = (dbus_REQCMD0 == REQ_READ) || (dbus_REQCMD0 == REQ_WRITE);

`ifdef CODIX_DBUS_MEM_ALIGN_CHK_EN
  assign req_bad = misaligned(req_size, dbus_A0[1:0]);
`else
  assign req_bad = 1'b0;
`endif

  assign addr_incr = addr_reg + (ADDR_W+2)'(size_incr(size_reg));
  // While streaming reads the Q register is refilled from the following beat
  // address so a beat can be consumed on every cycle.
  assign lane_addr = (state_reg == ST_RD) ? addr_incr : addr_reg;

  codix_dbus_byte_lane u_lane (
    .addr_lo       (lane_addr[1:0]),
    .size          (size_reg),
    .rdata         (rd_data),
    .wdata         (dbus_D0),
    .be            (be),
    .rdata_shifted (rdata_shifted),
    .wdata_repl    (wdata_repl)
  );

  // One byte-wide array per lane so each byte enable maps onto its own RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [0:(2**ADDR_W)-1];

    always_ff @(posedge CLK) begin
      if (wr_en && be[gi]) begin
        mem_lane[addr_reg[ADDR_W+1:2]] <= wdata_repl[8*gi +: 8];
      end
    end

    assign rd_data[8*gi +: 8] = mem_lane[lane_addr[ADDR_W+1:2]];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      size_reg     <= SZ_WORD;
      beats_reg    <= '0;
      wait_reg     <= '0;
      req_resp_reg <= RESP_WAIT;
      q_reg        <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      size_reg     <= size_next;
      beats_reg    <= beats_next;
      wait_reg     <= wait_next;
      req_resp_reg <= req_resp_next;
      q_reg        <= q_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    size_next     = size_reg;
    beats_next    = beats_reg;
    wait_next     = wait_reg;
    req_resp_next = RESP_WAIT;
    q_next        = q_reg;
    err_next      = 1'b0;
    if_ack        = 1'b0;
    of_ack        = 1'b0;
    wr_en         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            req_resp_next = RESP_ERR;
            err_next      = 1'b1;
          end else begin
            req_resp_next = RESP_ACK;
            addr_next     = {dbus_A0[ADDR_W+1:2], req_lo};
            size_next     = req_size_eff;
            beats_next    = {1'b0, dbus_SC0} + 4'd1;
            if (dbus_REQCMD0 == REQ_READ) begin
              wait_next  = WAIT_INIT;
              state_next = ST_RD_WAIT;
            end else begin
              state_next = ST_WR;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (wait_reg == 4'd0) begin
          q_next     = rdata_shifted;
          state_next = ST_RD;
        end else begin
          wait_next = wait_reg - 4'd1;
        end
      end
      ST_RD: begin
        if (dbus_IFCMD0 == IF_READ) begin
          if_ack     = 1'b1;
          addr_next  = addr_incr;
          q_next     = rdata_shifted;
          beats_next = beats_reg - 4'd1;
          if (beats_reg == 4'd1) state_next = ST_IDLE;
        end
      end
      ST_WR: begin
        if (dbus_OFCMD0 == OF_WRITE) begin
          of_ack     = 1'b1;
          wr_en      = 1'b1;
          addr_next  = addr_incr;
          beats_next = beats_reg - 4'd1;
          if (beats_reg == 4'd1) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dbus_REQRESP0 = req_resp_reg;
  assign dbus_Q0       = q_reg;
  assign dbus_IFRESP0  = if_ack ? RESP_ACK : RESP_WAIT;
  assign dbus_OFRESP0  = of_ack ? RESP_ACK : RESP_WAIT;
  assign busy_o        = (state_reg != ST_IDLE);
  assign err_o         = err_reg;

endmodule
